// File: rtl/intg_cap_pkg.sv
// Shared definitions for the integrator capture block: FSM state encodings,
// default geometry and the width of one captured {cycles, count} entry.
// No logic; imported by intg_capture and intg_cap_fifo.
package intg_cap_pkg;

    localparam int CW_DEF    = 4;   // integrator count width
    localparam int TW_DEF    = 8;   // run-cycle timer width
    localparam int DEPTH_DEF = 4;   // capture FIFO entries

    // 2'b11 is unused and recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10
    } state_e;

    function automatic int entry_w(input int tw, input int cw);
        return tw + cw;
    endfunction

endpackage

// File: rtl/intg_cap_fifo.sv
// Synchronous FIFO holding captured entries; head is exposed from registers.
// Latency: a write is visible at the head one cycle later (no bypass).
// Backpressure: wr_rdy_o drops when full unless a pop happens in the same cycle.
//
// Ports: clk, rst_n (async active-low); wr_vld_i/wr_dat_i/wr_rdy_o write side;
//        rd_rdy_i/rd_vld_o/rd_dat_o read side (rd_dat_o is 0 when empty); full_o.
module intg_cap_fifo
    import intg_cap_pkg::*;
#(
    parameter int DW    = entry_w(TW_DEF, CW_DEF),
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_vld_i,
    input  logic [DW-1:0] wr_dat_i,
    output logic          wr_rdy_o,
    input  logic          rd_rdy_i,
    output logic          rd_vld_o,
    output logic [DW-1:0] rd_dat_o,
    output logic          full_o
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry an extra wrap bit to tell full from empty.
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [DW-1:0] mem_q [DEPTH];
    logic          empty;
    logic          do_push, do_pop;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop   = rd_rdy_i & ~empty;
    // A pop frees the slot being written, so push-while-full is accepted then.
    assign wr_rdy_o = ~full_o | do_pop;
    assign do_push  = wr_vld_i & wr_rdy_o;

    assign rd_vld_o = ~empty;
    assign rd_dat_o = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // Storage needs no reset: it is only observed through a non-empty head.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_i;
    end

endmodule

// File: rtl/intg_capture.sv
// Times integrator runs (start -> rising done) and queues {cycles, count}.
// Latency: a capture appears on out_valid one cycle after done rises.
// Backpressure: FIFO absorbs stalls; a capture arriving while full is dropped and flags overflow.
//
// Ports: clk, reset_n (async active-low); start, done, cnt from the integrator;
//        out_valid/out_ready/out_data result stream; fifo_full; overflow (sticky).
// Build option: define INTG_CAP_DROPCNT_EN to add drop_cnt, a saturating
//        4-bit count of dropped captures.
module intg_capture
    import intg_cap_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int CW    = CW_DEF,
    parameter int TW    = TW_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                done,
    input  logic [CW-1:0]       cnt,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [TW+CW-1:0]    out_data,
    output logic                fifo_full,
    output logic                overflow
`ifdef INTG_CAP_DROPCNT_EN
    ,
    output logic [3:0]          drop_cnt
`endif
);

    localparam int DW = entry_w(TW, CW);

    state_e          state_q;
    logic [TW-1:0]   cyc_q;
    logic [TW-1:0]   cyc_d;
    logic            done_q;
    logic            ovf_q;
    logic            done_rise;
    logic            push_req;
    logic            push_rdy;
    logic            drop;

    assign done_rise = done & ~done_q;
    // Restart wins over completion when both happen in the same cycle.
    assign push_req  = (state_q == ST_RUN) & ~start & done_rise;
    assign drop      = push_req & ~push_rdy;
    // Timer saturates rather than wrapping so long runs read as "at least max".
    assign cyc_d     = (cyc_q == '1) ? cyc_q : cyc_q + TW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= done;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_RUN;
                        cyc_q   <= '0;
                    end
                end
                ST_RUN: begin
                    if (start) begin
                        cyc_q <= '0;
                    end else if (done_rise) begin
                        state_q <= ST_HOLD;
                    end else begin
                        cyc_q <= cyc_d;
                    end
                end
                // Wait for done to fall so a still-high done cannot re-trigger.
                ST_HOLD: begin
                    if (!done) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
            if (drop) ovf_q <= 1'b1;
        end
    end

    assign overflow = ovf_q;

`ifdef INTG_CAP_DROPCNT_EN
    logic [3:0] drop_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_q <= '0;
        end else if (drop && drop_cnt_q != 4'hF) begin
            drop_cnt_q <= drop_cnt_q + 4'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    intg_cap_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (reset_n),
        .wr_vld_i (push_req),
        .wr_dat_i ({cyc_q, cnt}),
        .wr_rdy_o (push_rdy),
        .rd_rdy_i (out_ready),
        .rd_vld_o (out_valid),
        .rd_dat_o (out_data),
        .full_o   (fifo_full)
    );

endmodule
